mtr_duty_ramp: RTL and testbench



---
 rtl/mtr_duty_ramp_pkg.sv | 11 +
 rtl/mtr_duty_ramp_if.sv | 15 +
 rtl/mtr_duty_ramp_dead_timer.sv | 29 ++
 rtl/mtr_duty_ramp.sv | 121 ++++++++++++
 tb/tb_mtr_duty_ramp.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mtr_duty_ramp_pkg.sv
// Shared widths and state encoding for the motor duty ramp block.
package mtr_duty_ramp_pkg;
  localparam int DUTY_W = 11;
  localparam int CMD_W  = 12;
  localparam int CNT_W  = 4;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } ramp_state_t;
endpackage

// File: rtl/mtr_duty_ramp_if.sv
// Command/PWM-side bundle: the controller drives the command and sync,
// the ramp block returns duty, direction and the at-target flag.
interface mtr_duty_ramp_if;
  import mtr_duty_ramp_pkg::*;

  logic signed [CMD_W-1:0] cmd;
  logic                    cmd_vld;
  logic                    pwm_sync;
  logic [DUTY_W-1:0]       duty;
  logic                    dir;
  logic                    at_tgt;

  modport master (output cmd, cmd_vld, pwm_sync, input duty, dir, at_tgt);
  modport slave  (input cmd, cmd_vld, pwm_sync, output duty, dir, at_tgt);
endinterface

// File: rtl/mtr_duty_ramp_dead_timer.sv
// Loadable down-counter that times the zero-duty interval before a
// direction reversal. expire flags the tick that consumes the last count.
module mtr_duty_ramp_dead_timer
  import mtr_duty_ramp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_expire,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Load has priority; ticks count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_tick && (r_cnt == CNT_W'(1));
  assign o_cnt    = r_cnt;
endmodule

// File: rtl/mtr_duty_ramp.sv
// Signed motor command to slew-limited, saturated 11-bit duty plus direction
// for the PWM stage. Outputs move only on the PWM period-start pulse, and a
// zero-duty dead interval separates every drive reversal.
module mtr_duty_ramp
  import mtr_duty_ramp_pkg::*;
#(
  parameter int STEP         = 16,
  parameter int DEAD_PERIODS = 2,
  parameter int MAX_DUTY     = 2040
) (
  input logic            clk,
  input logic            rst,
  mtr_duty_ramp_if.slave bus
);
  localparam logic signed [CMD_W:0]   STEP_S = (CMD_W+1)'(STEP);
  localparam logic signed [CMD_W-1:0] MAX_S  = CMD_W'(MAX_DUTY);

  // Saturate a raw command to the symmetric duty limit.
  function automatic logic signed [CMD_W-1:0] clamp_cmd(input logic signed [CMD_W-1:0] v);
    if (v > MAX_S)       return MAX_S;
    else if (v < -MAX_S) return -MAX_S;
    else                 return v;
  endfunction

  // Move from toward goal by at most STEP; the 13-bit difference cannot overflow
  // and the clamped move never overshoots goal.
  function automatic logic signed [CMD_W-1:0] step_toward(input logic signed [CMD_W-1:0] from,
                                                          input logic signed [CMD_W-1:0] goal);
    logic signed [CMD_W:0] diff;
    diff = {goal[CMD_W-1], goal} - {from[CMD_W-1], from};
    if (diff > STEP_S)       diff = STEP_S;
    else if (diff < -STEP_S) diff = -STEP_S;
    return from + diff[CMD_W-1:0];
  endfunction

  // Magnitude of a value already limited to MAX_DUTY.
  function automatic logic [DUTY_W-1:0] mag(input logic signed [CMD_W-1:0] v);
    logic [CMD_W-1:0] a;
    a = v[CMD_W-1] ? -v : v;
    return DUTY_W'(a);
  endfunction

  ramp_state_t             r_state, w_state_nxt;
  logic signed [CMD_W-1:0] r_cur, r_tgt, w_cur_nxt, w_tgt_nxt, w_goal;
  logic                    r_dir, w_dir_nxt;
  logic [DUTY_W-1:0]       r_duty;
  logic                    r_at_tgt;
  logic                    w_load, w_tick, w_expire;
  logic [CNT_W-1:0]        w_dead_cnt;

  assign w_tick = bus.pwm_sync && (r_state == DEAD);

  mtr_duty_ramp_dead_timer u_dead_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_W'(DEAD_PERIODS)),
    .i_tick     (w_tick),
    .o_expire   (w_expire),
    .o_cnt      (w_dead_cnt)
  );

  // Next-period value of cur/dir/state and the next target.
  always_comb begin
    w_cur_nxt   = r_cur;
    w_dir_nxt   = r_dir;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_goal      = r_tgt;
    if (bus.pwm_sync) begin
      if (r_state == DEAD) begin
        // An empty counter also releases DEAD so the block can never stick there.
        if (w_expire || (w_dead_cnt == '0)) begin
          w_dir_nxt   = ~r_dir;
          w_state_nxt = RUN;
        end
      end else if (r_cur != r_tgt) begin
        if ((r_cur == '0) && (r_tgt[CMD_W-1] != r_dir)) begin
          if (DEAD_PERIODS == 0) begin
            w_dir_nxt = ~r_dir;
          end else begin
            w_state_nxt = DEAD;
            w_load      = 1'b1;
          end
        end else begin
          // Opposite-sign or zero target: unwind to zero first, never crossing it.
          if ((r_tgt == '0) || ((r_cur != '0) && (r_tgt[CMD_W-1] != r_cur[CMD_W-1])))
            w_goal = '0;
          w_cur_nxt = step_toward(r_cur, w_goal);
        end
      end
    end
    w_tgt_nxt = bus.cmd_vld ? clamp_cmd(bus.cmd) : r_tgt;
  end

  // Ramp FSM and registered outputs; the step always uses the pre-capture target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_cur    <= '0;
      r_tgt    <= '0;
      r_dir    <= 1'b0;
      r_duty   <= '0;
      r_at_tgt <= 1'b1;
    end else begin
      if (bus.cmd_vld) r_tgt <= w_tgt_nxt;
      if (bus.pwm_sync) begin
        r_state <= w_state_nxt;
        r_cur   <= w_cur_nxt;
        r_dir   <= w_dir_nxt;
        r_duty  <= mag(w_cur_nxt);
      end
      if (bus.pwm_sync || bus.cmd_vld)
        r_at_tgt <= (w_cur_nxt == w_tgt_nxt) && (w_state_nxt == RUN);
    end
  end

  assign bus.duty   = r_duty;
  assign bus.dir    = r_dir;
  assign bus.at_tgt = r_at_tgt;
endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Bench for mtr_duty_ramp: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_mtr_duty_ramp;
  localparam int STEP = 16;
  localparam int DP   = 2;
  localparam int MAXD = 2040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tot = 0;
  int   bad = 0;

  mtr_duty_ramp_if bus();

  mtr_duty_ramp #(.STEP(STEP), .DEAD_PERIODS(DP), .MAX_DUTY(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: signed current value, target, direction, remaining dead periods.
  int m_cur = 0, m_tgt = 0, m_dir = 0, m_dead = 0;

  function automatic int clampi(input int v);
    if (v > MAXD)  return MAXD;
    if (v < -MAXD) return -MAXD;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_period();
    int goal, d, tneg;
    tneg = (m_tgt < 0) ? 1 : 0;
    if (m_dead > 0) begin
      if (m_dead == 1) m_dir = 1 - m_dir;
      m_dead = m_dead - 1;
    end else if (m_cur != m_tgt) begin
      if (m_cur == 0 && tneg != m_dir) begin
        if (DP == 0) m_dir = 1 - m_dir;
        else         m_dead = DP;
      end else begin
        goal = m_tgt;
        if (m_tgt == 0 || (m_cur != 0 && (m_tgt < 0) != (m_cur < 0))) goal = 0;
        d = goal - m_cur;
        if (d > STEP)  d = STEP;
        if (d < -STEP) d = -STEP;
        m_cur = m_cur + d;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cur = 0; m_tgt = 0; m_dir = 0; m_dead = 0;
      end else begin
        if (bus.pwm_sync) model_period();
        if (bus.cmd_vld)  m_tgt = clampi(int'(bus.cmd));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_duty", int'(bus.duty), absi(m_cur));
      chk("m_dir", int'(bus.dir), m_dir);
      chk("m_at_tgt", int'(bus.at_tgt), (m_cur == m_tgt && m_dead == 0) ? 1 : 0);
      chk("duty_lim", (int'(bus.duty) <= MAXD) ? 1 : 0, 1);
    end
  end

  task automatic tick(input logic v, input int c);
    bus.pwm_sync = 1'b1; bus.cmd_vld = v; bus.cmd = 12'(c);
    @(negedge clk);
    bus.pwm_sync = 1'b0; bus.cmd_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic cap(input int c);
    bus.cmd_vld = 1'b1; bus.cmd = 12'(c);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    chk("rst_duty", int'(bus.duty), 0);
    chk("rst_dir", int'(bus.dir), 0);
    chk("rst_at_tgt", int'(bus.at_tgt), 1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  int seq_fwd[7] = '{16, 32, 48, 64, 80, 96, 100};
  int seq_dn[7]  = '{84, 68, 52, 36, 20, 4, 0};
  int seq_up[4]  = '{16, 32, 48, 50};

  initial begin
    bus.cmd = '0; bus.cmd_vld = 1'b0; bus.pwm_sync = 1'b0;

    // Held reset with activity on the inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.pwm_sync = i[0]; bus.cmd_vld = ~i[0]; bus.cmd = 12'(500);
    end
    @(negedge clk);
    bus.pwm_sync = 1'b0; bus.cmd_vld = 1'b0;
    chk("hold_duty", int'(bus.duty), 0);
    chk("hold_at_tgt", int'(bus.at_tgt), 1);
    rst = 1'b0;
    @(negedge clk);

    // Forward ramp.
    cap(100);
    chk("fwd_at_tgt0", int'(bus.at_tgt), 0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 0);
      chk("fwd_duty", int'(bus.duty), seq_fwd[i]);
    end
    chk("fwd_at_tgt1", int'(bus.at_tgt), 1);
    tick(1'b0, 0); tick(1'b0, 0);
    chk("fwd_hold", int'(bus.duty), 100);

    // Reversal through the dead interval.
    cap(-50);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 0);
      chk("rev_duty", int'(bus.duty), seq_dn[i]);
      chk("rev_dir0", int'(bus.dir), 0);
    end
    tick(1'b0, 0);
    chk("dead_at_tgt", int'(bus.at_tgt), 0);
    chk("dead_dir", int'(bus.dir), 0);
    tick(1'b0, 0);
    chk("dead2_dir", int'(bus.dir), 0);
    tick(1'b0, 0);
    chk("flip_dir", int'(bus.dir), 1);
    chk("flip_duty", int'(bus.duty), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0);
      chk("rev_up", int'(bus.duty), seq_up[i]);
    end
    chk("rev_at_tgt", int'(bus.at_tgt), 1);

    // Simultaneous strobe: step uses the old target.
    cap(0);
    repeat (4) tick(1'b0, 0);
    chk("unwind", int'(bus.duty), 0);
    cap(64);
    repeat (3) tick(1'b0, 0);
    chk("fwd_again_dir", int'(bus.dir), 0);
    repeat (2) tick(1'b0, 0);
    chk("pre_sim", int'(bus.duty), 32);
    tick(1'b1, 40);
    chk("sim_old_tgt", int'(bus.duty), 48);
    chk("sim_at_tgt0", int'(bus.at_tgt), 0);
    tick(1'b0, 0);
    chk("sim_new_tgt", int'(bus.duty), 40);
    chk("sim_at_tgt1", int'(bus.at_tgt), 1);

    // Saturation in both directions.
    cap(2047);
    repeat (130) tick(1'b0, 0);
    chk("sat_pos", int'(bus.duty), 2040);
    chk("sat_pos_at", int'(bus.at_tgt), 1);
    cap(-2048);
    chk("sat_neg_at0", int'(bus.at_tgt), 0);
    repeat (262) tick(1'b0, 0);
    chk("sat_neg", int'(bus.duty), 2040);
    chk("sat_neg_dir", int'(bus.dir), 1);
    chk("sat_neg_at1", int'(bus.at_tgt), 1);

    // Reset while in DEAD, then a fresh reversal.
    cap(0);
    repeat (130) tick(1'b0, 0);
    chk("zero_dir", int'(bus.dir), 1);
    cap(5);
    tick(1'b0, 0);
    chk("in_dead", int'(bus.at_tgt), 0);
    pulse_rst();
    cap(-20);
    tick(1'b0, 0);
    chk("r6_dead", int'(bus.at_tgt), 0);
    tick(1'b0, 0);
    chk("r6_dir0", int'(bus.dir), 0);
    tick(1'b0, 0);
    chk("r6_dir1", int'(bus.dir), 1);
    chk("r6_duty0", int'(bus.duty), 0);
    tick(1'b0, 0);
    chk("r6_duty16", int'(bus.duty), 16);
    tick(1'b0, 0);
    chk("r6_duty20", int'(bus.duty), 20);
    chk("r6_at_tgt", int'(bus.at_tgt), 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bus.pwm_sync = ($urandom_range(0, 2) == 0);
      bus.cmd_vld  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) bus.cmd = 12'($urandom);
      else                           bus.cmd = 12'(int'($urandom_range(0, 160)) - 80);
      if ($urandom_range(0, 699) == 0) begin
        bus.pwm_sync = 1'b0; bus.cmd_vld = 1'b0;
        pulse_rst();
      end else begin
        @(negedge clk);
      end
    end
    bus.pwm_sync = 1'b0; bus.cmd_vld = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
